// File: rtl/kmeans_job_sequencer_if.sv
// APB bus between the job sequencer (master) and the k_means_top slave port.
//   paddr/pwrite/psel/penable/pwdata : master -> slave request
//   prdata/pready                    : slave -> master response
interface kmeans_job_sequencer_if #(
    parameter int unsigned addrWidth = 9,
    parameter int unsigned dataWidth = 91
);
    logic [addrWidth-1:0] paddr;
    logic                 pwrite;
    logic                 psel;
    logic                 penable;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/kmeans_job_sequencer.sv
// Runs one complete k-means job on k_means_top over APB: loads 8 initial
// centroids and N points from an upstream stream, kicks the core, waits for
// its interrupt (with a watchdog) and streams the 8 final centroids out.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start/first/last    : job request and RAM point range (sampled in IDLE)
//   pt_valid/data/ready : upstream word stream (centroids first, then points)
//   apb                 : APB master port to the core
//   interupt            : core-done level
//   res_valid/idx/data  : final centroid strobe
//   busy/done/err       : job status (done/err are one-cycle pulses)
module kmeans_job_sequencer #(
    parameter int unsigned addrWidth     = 9,
    parameter int unsigned dataWidth     = 91,
    parameter int unsigned centroid_num  = 8,
    parameter int unsigned timeout_width = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [addrWidth-1:0]          first_addr,
    input  logic [addrWidth-1:0]          last_addr,
    input  logic                          pt_valid,
    input  logic [dataWidth-1:0]          pt_data,
    output logic                          pt_ready,
    kmeans_job_sequencer_if.master        apb,
    input  logic                          interupt,
    output logic                          res_valid,
    output logic [2:0]                    res_idx,
    output logic [dataWidth-1:0]          res_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned CW           = (centroid_num > 1) ? $clog2(centroid_num) : 1;
    localparam int unsigned REG_GO       = 1;
    localparam int unsigned REG_CENT0    = 2;
    localparam int unsigned REG_RAM_ADDR = 10;
    localparam int unsigned REG_RAM_DATA = 11;
    localparam int unsigned REG_FIRST    = 12;
    localparam int unsigned REG_LAST     = 13;

    localparam logic [CW-1:0]            CNT_LAST = CW'(centroid_num - 1);
    localparam logic [timeout_width-1:0] WD_ALL   = '1;
    localparam logic [timeout_width-1:0] WD_LAST  = WD_ALL - timeout_width'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_ACCESS, S_GAP, S_WAIT_IRQ, S_DONE
    } state_t;

    // Which step of the job the current fetch/transfer belongs to.
    typedef enum logic [2:0] {
        PH_CENT, PH_FIRST, PH_LAST, PH_PADDR, PH_PDATA, PH_GO, PH_READ
    } phase_t;

    state_t                   state, state_n;
    phase_t                   phase, phase_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic [addrWidth-1:0]     pt_addr, pt_addr_n;
    logic [addrWidth-1:0]     first_q, first_n;
    logic [addrWidth-1:0]     last_q, last_n;
    logic [dataWidth-1:0]     word_q, word_n;
    logic [timeout_width-1:0] wd, wd_n;

    logic                     err_n, done_n, rv_n;
    logic [2:0]               ridx_n;
    logic [dataWidth-1:0]     rdata_n;
    logic [addrWidth-1:0]     paddr_n;
    logic                     pwrite_n;
    logic [dataWidth-1:0]     pwdata_n;

    // Only output decoded straight from state.
    assign pt_ready = (state == S_FETCH);

    // Next-state, step sequencing and next values of the registered outputs.
    always_comb begin
        state_n   = state;
        phase_n   = phase;
        cnt_n     = cnt;
        pt_addr_n = pt_addr;
        first_n   = first_q;
        last_n    = last_q;
        word_n    = word_q;
        wd_n      = wd;
        err_n     = 1'b0;
        done_n    = 1'b0;
        rv_n      = 1'b0;
        ridx_n    = res_idx;
        rdata_n   = res_data;
        paddr_n   = apb.paddr;
        pwrite_n  = apb.pwrite;
        pwdata_n  = apb.pwdata;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (last_addr < first_addr) begin
                        err_n = 1'b1;
                    end else begin
                        first_n   = first_addr;
                        last_n    = last_addr;
                        pt_addr_n = first_addr;
                        phase_n   = PH_CENT;
                        cnt_n     = '0;
                        state_n   = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (pt_valid) begin
                    word_n  = pt_data;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: state_n = S_ACCESS;
            S_ACCESS: begin
                if (apb.pready) begin
                    state_n = S_GAP;
                    if (phase == PH_READ) begin
                        rv_n    = 1'b1;
                        ridx_n  = 3'(cnt);
                        rdata_n = apb.prdata;
                    end
                end
            end
            S_GAP: begin
                case (phase)
                    PH_CENT: begin
                        if (cnt == CNT_LAST) begin
                            cnt_n   = '0;
                            phase_n = PH_FIRST;
                            state_n = S_SETUP;
                        end else begin
                            cnt_n   = cnt + CW'(1);
                            state_n = S_FETCH;
                        end
                    end
                    PH_FIRST: begin
                        phase_n = PH_LAST;
                        state_n = S_SETUP;
                    end
                    PH_LAST: begin
                        phase_n = PH_PADDR;
                        state_n = S_FETCH;
                    end
                    PH_PADDR: begin
                        phase_n = PH_PDATA;
                        state_n = S_SETUP;
                    end
                    PH_PDATA: begin
                        // Compare against last before incrementing so last=max never wraps.
                        if (pt_addr == last_q) begin
                            phase_n = PH_GO;
                            state_n = S_SETUP;
                        end else begin
                            pt_addr_n = pt_addr + addrWidth'(1);
                            phase_n   = PH_PADDR;
                            state_n   = S_FETCH;
                        end
                    end
                    PH_GO: begin
                        wd_n    = '0;
                        state_n = S_WAIT_IRQ;
                    end
                    PH_READ: begin
                        if (cnt == CNT_LAST) begin
                            state_n = S_DONE;
                        end else begin
                            cnt_n   = cnt + CW'(1);
                            state_n = S_SETUP;
                        end
                    end
                    default: state_n = S_IDLE;
                endcase
            end
            S_WAIT_IRQ: begin
                if (interupt) begin
                    phase_n = PH_READ;
                    cnt_n   = '0;
                    state_n = S_SETUP;
                end else if (wd == WD_LAST) begin
                    wd_n    = WD_ALL;
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    wd_n = wd + timeout_width'(1);
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Transfer fields load on SETUP entry and hold through ACCESS.
        if (state_n == S_SETUP) begin
            case (phase_n)
                PH_CENT: begin
                    paddr_n  = addrWidth'(REG_CENT0 + 32'(cnt_n));
                    pwrite_n = 1'b1;
                    pwdata_n = word_n;
                end
                PH_FIRST: begin
                    paddr_n  = addrWidth'(REG_FIRST);
                    pwrite_n = 1'b1;
                    pwdata_n = dataWidth'(first_n);
                end
                PH_LAST: begin
                    paddr_n  = addrWidth'(REG_LAST);
                    pwrite_n = 1'b1;
                    pwdata_n = dataWidth'(last_n);
                end
                PH_PADDR: begin
                    paddr_n  = addrWidth'(REG_RAM_ADDR);
                    pwrite_n = 1'b1;
                    pwdata_n = dataWidth'(pt_addr_n);
                end
                PH_PDATA: begin
                    paddr_n  = addrWidth'(REG_RAM_DATA);
                    pwrite_n = 1'b1;
                    pwdata_n = word_n;
                end
                PH_GO: begin
                    paddr_n  = addrWidth'(REG_GO);
                    pwrite_n = 1'b1;
                    pwdata_n = dataWidth'(1);
                end
                PH_READ: begin
                    paddr_n  = addrWidth'(REG_CENT0 + 32'(cnt_n));
                    pwrite_n = 1'b0;
                    pwdata_n = '0;
                end
                default: begin
                    paddr_n  = '0;
                    pwrite_n = 1'b0;
                    pwdata_n = '0;
                end
            endcase
        end
    end

    // State, step context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            phase       <= PH_CENT;
            cnt         <= '0;
            pt_addr     <= '0;
            first_q     <= '0;
            last_q      <= '0;
            word_q      <= '0;
            wd          <= '0;
            apb.paddr   <= '0;
            apb.pwrite  <= 1'b0;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            apb.pwdata  <= '0;
            res_valid   <= 1'b0;
            res_idx     <= '0;
            res_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            cnt         <= cnt_n;
            pt_addr     <= pt_addr_n;
            first_q     <= first_n;
            last_q      <= last_n;
            word_q      <= word_n;
            wd          <= wd_n;
            apb.paddr   <= paddr_n;
            apb.pwrite  <= pwrite_n;
            apb.psel    <= (state_n == S_SETUP) || (state_n == S_ACCESS);
            apb.penable <= (state_n == S_ACCESS);
            apb.pwdata  <= pwdata_n;
            res_valid   <= rv_n;
            res_idx     <= ridx_n;
            res_data    <= rdata_n;
            busy        <= (state_n != S_IDLE);
            done        <= done_n;
            err         <= err_n;
        end
    end

endmodule
